uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1_600_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 10_000, line bit rate in baud.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port RXD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  DATA_WIDTH  received byte, LSB first on the line.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 SHALL have port rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port rx_overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-012 SHALL pass RXD through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-013 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD_RATE*16) clocks (integer division); DIV >= 2 required.
REQ-014 SHALL restart the tick counter at 0 on start-edge detection so ticks are phase-aligned to the frame.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: synchronized RXD low -> START, tick count cleared.
REQ-017 START: at 8th tick sample RXD; low -> DATA, high -> IDLE (glitch rejected, no output).
REQ-018 DATA: sample each bit every 16 ticks after the start mid-point, shift in LSB first; after DATA_WIDTH bits -> STOP.
REQ-019 STOP: sample 16 ticks after the last data mid-point; high -> deliver byte, IDLE; low -> pulse rx_frame_err, discard byte, WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until synchronized RXD high, then IDLE (break condition yields one error only).
REQ-021 Delivery: rx_data updated and rx_valid set on the cycle after the stop sample.
REQ-022 rx_valid SHALL stay high and rx_data stable until a cycle with rx_valid && rx_ready; rx_valid clears on the following edge.
REQ-023 If a byte completes while rx_valid high and rx_ready low: old byte kept, new byte dropped, rx_overrun pulses one cycle.
REQ-024 If a byte completes in the same cycle as acceptance (rx_valid && rx_ready): new byte loaded, rx_valid stays high, no overrun.
REQ-025 Bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide; tick counter 4 bits wrapping 15->0.
REQ-026 rx_ready is ignored while rx_valid low.

Reset
REQ-027 On RST high, immediately: state IDLE, synchronizer flops 1, counters 0, rx_data 0, rx_valid 0, rx_frame_err 0, rx_overrun 0.
REQ-028 RST asserted mid-frame SHALL abandon the frame; after release a byte is received only from a new start edge.

Structure
REQ-029 Shared package uart_pkg SHALL hold OVERSAMPLE=16, state encodings, and the DIV computation function.
REQ-030 Oversample tick generator SHALL be a sub-module uart_baud_gen (inputs CLK, RST, clear; output tick).

Verification (CLK_FREQ 1_600_000, BAUD_RATE 10_000 -> DIV 10, 160 clocks/bit)
REQ-031 Frame 0xA5, rx_ready held high -> rx_valid one cycle, rx_data 0xA5, no error pulses.
REQ-032 Frames 0x3C then 0xC3, rx_ready low throughout -> rx_data stays 0x3C, rx_overrun pulses once at second stop sample.
REQ-033 Frame 0x55 with stop bit driven low, then line high -> rx_frame_err single pulse, rx_valid never set, next frame 0x12 received correctly.
REQ-034 RXD low pulse of 40 clocks in idle -> no rx_valid, no error; subsequent frame 0x81 received correctly.
REQ-035 RST asserted during bit 4 of 0xF0, released, then frame 0x0F -> all outputs 0 in reset, only 0x0F delivered.
REQ-036 Back-to-back frames 0x01,0x02,0x03 with rx_ready pulsed one cycle per rx_valid -> three bytes in order, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state encoding and baud divider helper for the UART receiver
// No ports: imported by uart_baud_gen and uart_rx_ctrl.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // Clocks per oversample tick; integer division truncates toward zero.
   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return clk_freq / (baud_rate * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - 16x oversample tick generator with phase restart
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   asynchronous active-high reset
//   clear in   restart the divider at 0 (start edge alignment)
//   tick  out  one-cycle pulse every DIV clocks
module uart_baud_gen #(
   parameter int DIV = 10
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A clear cycle never produces a tick, so the first tick after a start
   // edge always lands a full DIV clocks later.
   assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receiver with valid/ready output, framing and overrun flags
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   RXD          in   asynchronous serial line, idle high
//   rx_data      out  received word, LSB first on the line
//   rx_valid     out  rx_data holds an unconsumed word
//   rx_ready     in   consumer accepts rx_data when high with rx_valid
//   rx_frame_err out  one-cycle pulse on a bad stop bit
//   rx_overrun   out  one-cycle pulse when a completed word is dropped
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 1_600_000,
   parameter int BAUD_RATE  = 10_000,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RXD,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_frame_err,
   output logic                  rx_overrun
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int BW  = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
   localparam logic [3:0]    MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    FULL_TICK = 4'(OVERSAMPLE - 1);

   logic                  rxd_s1_q, rxd_s2_q;
   rx_state_t             state_q, state_d;
   logic [3:0]            tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ferr_q, ferr_d;
   logic                  ovr_q, ovr_d;
   logic                  tick, baud_clear, byte_done, accept;

   uart_baud_gen #(.DIV(DIV)) u_baud_gen (
      .CLK   (CLK),
      .RST   (RST),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Frame decoder. The tick counter runs from the start-bit midpoint, so
   // every later sample falls on its 4-bit wrap from 15 back to 0.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      baud_clear = 1'b0;
      byte_done  = 1'b0;
      ferr_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxd_s2_q) begin
               state_d    = ST_START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               baud_clear = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == MID_TICK) begin
                  tick_cnt_d = '0;
                  state_d    = rxd_s2_q ? ST_IDLE : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == FULL_TICK) begin
                  shift_d = {rxd_s2_q, shift_q[DATA_WIDTH-1:1]};
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     state_d   = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == FULL_TICK) begin
                  if (rxd_s2_q) begin
                     byte_done = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_WAIT_IDLE;
                  end
               end
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low break reports one framing error, not one per frame time.
            if (rxd_s2_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output holding register: a completing word replaces the held one only
   // if the slot is empty or being emptied on this very edge.
   assign accept = valid_q && rx_ready;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (byte_done) begin
         if (!valid_q || accept) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rxd_s1_q   <= RXD;
         rxd_s2_q   <= rxd_s1_q;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with frame-level reference model
module tb_uart_rx_ctrl;

   localparam int BIT_CLKS = 160;
   // Edges from driving the start bit to rx_valid visible: 2 sync + 1 detect
   // + 80 to the start midpoint + 9 bit periods to the stop midpoint.
   localparam int LAT = 3 + 80 + 9 * BIT_CLKS;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RXD = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err, rx_overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         exp_t[$];
   int         exp_ferr = 0, exp_ovr = 0, got_ferr = 0, got_ovr = 0;
   int         mode = 0;
   bit         model_pending = 1'b0;
   int         acc_cyc = 0;
   int         frame_start = 0;
   int         last_data = 0, last_cyc = 0, n_new = 0, ovr_cyc = 0, ferr_cyc = 0;

   uart_rx_ctrl #(
      .CLK_FREQ   (1_600_000),
      .BAUD_RATE  (10_000),
      .DATA_WIDTH (8)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RXD          (RXD),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Consumer policy: 0 ready always, 1 ready never, 2 one-cycle pulse after a
   // short random delay, 3 a single pulse landing on edge acc_cyc.
   task automatic set_mode(input int m);
      mode = m;
      if (m != 1) model_pending = 1'b0;
   endtask

   // Frame-level model: a good word is delivered at its stop midpoint unless
   // the consumer is still sitting on an earlier word.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      frame_start = cyc;
      if (!stop_ok) begin
         exp_ferr++;
      end else if (mode == 1 && model_pending) begin
         exp_ovr++;
      end else begin
         exp_q.push_back(b);
         exp_t.push_back(cyc + LAT);
         if (mode == 1) model_pending = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      model_frame(b, stop_ok);
      for (int i = 0; i < 10; i++) begin
         RXD = bits[i];
         clks(BIT_CLKS);
      end
      RXD = 1'b1;
   endtask

   // Compare process: one sample per cycle on the falling edge.
   logic       pv = 1'b0, pr = 1'b0, pf = 1'b0, po = 1'b0;
   logic [7:0] pd = '0;
   bit         waiting = 1'b0;
   int         dly = 0;

   always @(negedge CLK) begin
      if (RST) begin
         chk("reset_outputs", {21'd0, rx_data, rx_valid, rx_frame_err, rx_overrun}, 32'd0);
         pv = 1'b0; pr = 1'b0; pf = 1'b0; po = 1'b0; pd = '0; waiting = 1'b0;
      end else begin
         if (rx_valid && (!pv || pr)) begin
            n_new++;
            last_data = rx_data;
            last_cyc  = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got 0x%0h with none expected (cycle %0d)", rx_data, cyc);
            end else begin
               chk("rx_data", rx_data, exp_q.pop_front());
               chk("deliver_cycle", cyc, exp_t.pop_front());
            end
         end else if (pv && !pr) begin
            chk("hold_valid", rx_valid, 1);
            chk("hold_data", rx_data, pd);
         end
         if (rx_frame_err) begin got_ferr++; ferr_cyc = cyc; end
         if (rx_overrun) begin got_ovr++; ovr_cyc = cyc; end
         if (rx_frame_err || rx_overrun) begin
            chk("ferr_pulse_width", pf & rx_frame_err, 0);
            chk("ovr_pulse_width", po & rx_overrun, 0);
         end
         pv = rx_valid; pd = rx_data; pf = rx_frame_err; po = rx_overrun;
         case (mode)
            0: rx_ready = 1'b1;
            1: rx_ready = 1'b0;
            3: rx_ready = (cyc == acc_cyc - 1);
            default: begin
               rx_ready = 1'b0;
               if (waiting) begin
                  if (dly == 0) begin
                     rx_ready = 1'b1;
                     waiting  = 1'b0;
                  end else begin
                     dly--;
                  end
               end else if (rx_valid) begin
                  waiting = 1'b1;
                  dly     = $urandom_range(0, 20);
               end
            end
         endcase
         pr = rx_ready;
      end
   end

   initial begin
      int         n0, o0, m;
      logic [7:0] b;
      bit         ok;
      logic [9:0] fbits;

      clks(5);
      RST = 1'b0;
      clks(20);

      // Single word, consumer always ready.
      set_mode(0);
      clks(5);
      send_frame(8'hA5, 1'b1);
      clks(40);
      chk("a5_data", last_data, 32'hA5);
      chk("a5_count", n_new, 1);
      chk("a5_latency", last_cyc - frame_start, 1523);
      chk("a5_no_errors", got_ferr + got_ovr, 0);

      // Two words, consumer never ready: first kept, second dropped.
      set_mode(1);
      clks(5);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      clks(40);
      chk("ovr_kept_data", rx_data, 32'h3C);
      chk("ovr_kept_valid", rx_valid, 1);
      chk("ovr_count", got_ovr, 1);
      chk("ovr_at_stop", ovr_cyc - frame_start, 1523);
      set_mode(0);
      clks(10);
      chk("ovr_drained", rx_valid, 0);

      // Bad stop bit, then a clean word.
      n0 = n_new;
      send_frame(8'h55, 1'b0);
      clks(30);
      chk("ferr_count", got_ferr, 1);
      chk("ferr_at_stop", ferr_cyc - frame_start, 1523);
      chk("ferr_no_valid", n_new - n0, 0);
      send_frame(8'h12, 1'b1);
      clks(40);
      chk("after_ferr_data", last_data, 32'h12);

      // Short low glitch on an idle line.
      n0 = n_new;
      RXD = 1'b0;
      clks(40);
      RXD = 1'b1;
      clks(200);
      chk("glitch_no_valid", n_new - n0, 0);
      chk("glitch_no_err", got_ferr, 1);
      send_frame(8'h81, 1'b1);
      clks(40);
      chk("after_glitch_data", last_data, 32'h81);

      // Reset in the middle of bit 4 of 0xF0, then a fresh word.
      n0 = n_new;
      fbits = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         RXD = fbits[i];
         clks(BIT_CLKS);
      end
      RXD = fbits[4];
      clks(80);
      RST = 1'b1;
      model_pending = 1'b0;
      clks(10);
      RXD = 1'b1;
      clks(5);
      RST = 1'b0;
      clks(50);
      chk("rst_no_valid", n_new - n0, 0);
      send_frame(8'h0F, 1'b1);
      clks(40);
      chk("after_rst_count", n_new - n0, 1);
      chk("after_rst_data", last_data, 32'h0F);

      // Back-to-back words, one ready pulse per word.
      n0 = n_new;
      o0 = got_ovr;
      set_mode(2);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      send_frame(8'h03, 1'b1);
      clks(60);
      chk("b2b_count", n_new - n0, 3);
      chk("b2b_last", last_data, 32'h03);
      chk("b2b_no_ovr", got_ovr - o0, 0);
      chk("b2b_empty", rx_valid, 0);

      // Word completing on the same edge the held word is accepted.
      set_mode(1);
      send_frame(8'h6E, 1'b1);
      clks(10);
      o0 = got_ovr;
      set_mode(3);
      acc_cyc = cyc + LAT;
      send_frame(8'h9B, 1'b1);
      clks(20);
      chk("same_edge_valid", rx_valid, 1);
      chk("same_edge_data", rx_data, 32'h9B);
      chk("same_edge_no_ovr", got_ovr - o0, 0);
      set_mode(0);
      clks(10);

      // Randomized words, stop bits and consumer behaviour.
      for (int k = 0; k < 14; k++) begin
         m  = $urandom_range(0, 2);
         b  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         set_mode(m);
         send_frame(b, ok);
         if (ok) clks($urandom_range(0, 30));
         else    clks($urandom_range(5, 40));
      end
      set_mode(0);
      clks(100);

      chk("final_ferr_total", got_ferr, exp_ferr);
      chk("final_ovr_total", got_ovr, exp_ovr);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
